// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants and inverse-cipher byte helpers
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] aes_128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_e;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry b sits (255-b) bytes above the LSB, i.e. at bit {~b, 3'b000}.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic aes_128 inv_sub_bytes(input aes_128 s);
        aes_128 o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte k of the block is row k%4, column k/4; row r rotates right by r.
    function automatic aes_128 inv_shift_rows(input aes_128 s);
        aes_128 o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// rtl/aes_inv_mix_column.sv - combinational InvMixColumns of one 32-bit state column
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] state_i,
    output logic [31:0] state_o
);

    // GF(2^8) multiply by a small constant via repeated xtime.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = state_i[31:24];
    assign a1 = state_i[23:16];
    assign a2 = state_i[15:8];
    assign a3 = state_i[7:0];

    assign state_o = {
        gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
        gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
        gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
        gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
    };

endmodule

// File: rtl/aes_dec_iter.sv
// rtl/aes_dec_iter.sv - iterative AES-128 decryptor, one round per clock, external key store
module aes_dec_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  aes_128       cipher_i,
    output logic [3:0]   rnd_idx_o,
    input  aes_128       rnd_key_i,
    input  logic         abort_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output aes_128       plain_o,
    output logic         busy_o
);

    localparam logic [3:0] IDX_LAST  = 4'(NR);
    localparam logic [3:0] CNT_FIRST = 4'(NR - 1);

    fsm_e       fsm_q, fsm_d;
    aes_128     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    aes_128     isb_w;
    aes_128     ark_w;
    aes_128     imc_w;
    logic       accept_w;

    assign accept_w = in_valid_i & in_ready_o;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state; abort overrides every handshake
    always_comb begin
        fsm_d = fsm_q;
        if (abort_i) begin
            fsm_d = ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE:  if (in_valid_i)   fsm_d = ST_ROUND;
                ST_ROUND: if (cnt_q == 4'd0) fsm_d = ST_DONE;
                ST_DONE:  if (out_ready_i)  fsm_d = ST_IDLE;
                default:  fsm_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; rnd_idx_o depends only on state and counter
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        rnd_idx_o   = 4'd0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                rnd_idx_o  = IDX_LAST;
            end
            ST_ROUND: begin
                busy_o    = 1'b1;
                rnd_idx_o = cnt_q;
            end
            ST_DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign isb_w = inv_sub_bytes(inv_shift_rows(state_q));
    assign ark_w = isb_w ^ rnd_key_i;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        aes_inv_mix_column u_imc (
            .state_i (ark_w[127 - 32*c -: 32]),
            .state_o (imc_w[127 - 32*c -: 32])
        );
    end

    // Round datapath: initial key add on accept, full rounds, final round without mixing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept_w) begin
                    state_d = cipher_i ^ rnd_key_i;
                    cnt_d   = CNT_FIRST;
                end
            end
            ST_ROUND: begin
                if (cnt_q == 4'd0) begin
                    state_d = ark_w;
                end else begin
                    state_d = imc_w;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // State and round counter registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= '0;
            cnt_q   <= CNT_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign plain_o = state_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// tb/tb_aes_dec_iter.sv - scoreboard bench for aes_dec_iter with FIPS-197 vectors
module tb_aes_dec_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         nrst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] cipher_i;
    logic [3:0]   rnd_idx_o;
    logic [127:0] rnd_key_i;
    logic         abort_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] plain_o;
    logic         busy_o;

    always #5 clk = ~clk;

    aes_dec_iter #(.NR(10)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .cipher_i    (cipher_i),
        .rnd_idx_o   (rnd_idx_o),
        .rnd_key_i   (rnd_key_i),
        .abort_i     (abort_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .plain_o     (plain_o),
        .busy_o      (busy_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- key store model ----------------
    logic [7:0]   sbox [256];
    logic [127:0] rk [2][11];
    int           key_sel = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input int sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always_comb rnd_key_i = (rnd_idx_o <= 4'd10) ? rk[key_sel][rnd_idx_o] : '0;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] plain;
        int           acc;
    } exp_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    logic [127:0] cur_exp = '0;
    int           acc_cnt = 0;
    int           last_acc = 0;
    int           rise_cyc = 0;
    logic         prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare on each output handshake, record acceptances, flush on abort/reset
    always @(negedge clk) begin
        if (nrst) begin
            if (out_valid_o) begin
                check("out_expected", 128'(exp_q.size() != 0), 128'd1);
                if (!prev_ov) rise_cyc = cyc;
                if (out_ready_i && !abort_i && exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("plain", plain_o, mon_e.plain);
                    check("latency", 128'(rise_cyc - mon_e.acc), 128'd11);
                end
            end
            prev_ov = out_valid_o;
        end
        if (!nrst || abort_i) begin
            exp_q.delete();
            prev_ov = 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            exp_q.push_back('{plain: cur_exp, acc: cyc});
            acc_cnt++;
            last_acc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid_o && n < 30) begin
            tick();
            n++;
        end
        check(name, 128'(out_valid_o), 128'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic send(input logic [127:0] c, input logic [127:0] p, input int ks);
        key_sel    = ks;
        cipher_i   = c;
        cur_exp    = p;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_ov"},    128'(out_valid_o), 128'd0);
        check({name, "_ready"}, 128'(in_ready_o),  128'd1);
        check({name, "_idx"},   128'(rnd_idx_o),   128'd10);
        check({name, "_busy"},  128'(busy_o),      128'd0);
    endtask

    initial begin
        int a0;
        int first_acc;
        int n;
        nrst        = 1'b0;
        in_valid_i  = 1'b0;
        abort_i     = 1'b0;
        out_ready_i = 1'b1;
        cipher_i    = '0;

        build_sbox();
        expand(0, C1_KEY);
        expand(1, B_KEY);
        check("keystore_c1_rk10", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("keystore_b_rk10",  rk[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // reset state
        repeat (3) tick();
        check_idle("reset");
        check("reset_plain", plain_o, 128'h0);
        nrst = 1'b1;
        tick();
        check("post_reset_ready", 128'(in_ready_o), 128'd1);
        check("post_reset_idx",   128'(rnd_idx_o),  128'd10);

        // C.1 vector
        send(C1_CT, C1_PT, 0);
        check("c1_busy",  128'(busy_o),     128'd1);
        check("c1_ready", 128'(in_ready_o), 128'd0);
        wait_drain("c1_drain");

        // B vector with round index sequence
        key_sel    = 1;
        cipher_i   = B_CT;
        cur_exp    = B_PT;
        in_valid_i = 1'b1;
        check("idx_idle", 128'(rnd_idx_o), 128'd10);
        tick();
        in_valid_i = 1'b0;
        for (int k = 9; k >= 0; k--) begin
            check("idx_round", 128'(rnd_idx_o), 128'(k));
            tick();
        end
        check("idx_done", 128'(rnd_idx_o),   128'd0);
        check("b_valid",  128'(out_valid_o), 128'd1);
        wait_drain("b_drain");

        // backpressure for 20 cycles, with in_valid_i asserted and ignored
        out_ready_i = 1'b0;
        send(C1_CT, C1_PT, 0);
        wait_valid("bp_wait_valid");
        in_valid_i = 1'b1;
        cipher_i   = B_CT;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 128'(out_valid_o), 128'd1);
            check("bp_plain", plain_o, C1_PT);
            check("bp_ready", 128'(in_ready_o), 128'd0);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        check("bp_release_ov",    128'(out_valid_o), 128'd0);
        check("bp_release_ready", 128'(in_ready_o),  128'd1);
        wait_drain("bp_drain");

        // abort at round 5
        send(C1_CT, C1_PT, 0);
        repeat (4) tick();
        check("abort_at_idx5", 128'(rnd_idx_o), 128'd5);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_idle("abort");
        repeat (15) tick();
        check("abort_no_out", 128'(out_valid_o), 128'd0);
        send(C1_CT, C1_PT, 0);
        wait_drain("after_abort_drain");

        // reset while holding a result in DONE
        out_ready_i = 1'b0;
        send(C1_CT, C1_PT, 0);
        wait_valid("rst_wait_valid");
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check_idle("rst_done");
        tick();
        check_idle("rst_done_after");
        out_ready_i = 1'b1;
        check("rst_queue_empty", 128'(exp_q.size()), 128'd0);

        // back-to-back with in_valid_i held high
        key_sel    = 0;
        cipher_i   = C1_CT;
        cur_exp    = C1_PT;
        a0         = acc_cnt;
        in_valid_i = 1'b1;
        n = 0;
        while (acc_cnt == a0 && n < 5) begin
            tick();
            n++;
        end
        check("b2b_first_accept", 128'(acc_cnt - a0), 128'd1);
        first_acc = last_acc;
        cipher_i  = B_CT;
        cur_exp   = B_PT;
        wait_valid("b2b_wait_valid");
        key_sel = 1;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 20) begin
            tick();
            n++;
        end
        in_valid_i = 1'b0;
        check("b2b_spacing", 128'(last_acc - first_acc), 128'd12);
        wait_drain("b2b_drain");
        repeat (15) tick();
        check("b2b_accept_count", 128'(acc_cnt - a0), 128'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_dec_iter.md
AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds; only 10 (AES-128) is supported.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port clk, input, 1 bit: single rising-edge clock.
REQ-004 Port nrst, input, 1 bit: synchronous active-low reset.
REQ-005 Port in_valid_i, input, 1 bit: ciphertext request valid.
REQ-006 Port in_ready_o, output, 1 bit: block can accept ciphertext.
REQ-007 Port cipher_i, input, aes_pkg::aes_128 (128 bits): ciphertext block.
REQ-008 Port rnd_idx_o, output, 4 bits: index of the round key requested from the external key store.
REQ-009 Port rnd_key_i, input, aes_pkg::aes_128: round key for rnd_idx_o, valid combinationally in the same cycle.
REQ-010 Port abort_i, input, 1 bit: synchronous abort of the current operation.
REQ-011 Port out_valid_o, output, 1 bit: plaintext valid.
REQ-012 Port out_ready_i, input, 1 bit: consumer accepts plaintext.
REQ-013 Port plain_o, output, aes_pkg::aes_128: decrypted block.
REQ-014 Port busy_o, output, 1 bit: high in the ROUND and DONE states.

Function
REQ-015 SHALL implement the FIPS-197 inverse cipher, one round per clock; the key schedule is external.
REQ-016 FSM states SHALL be IDLE, ROUND and DONE.
REQ-017 IDLE: in_ready_o=1 and rnd_idx_o=10; on in_valid_i&in_ready_o, state <= cipher_i ^ rnd_key_i, round counter <= 9, go to ROUND.
REQ-018 ROUND, counter r in 9..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rnd_key_i), rnd_idx_o=r, r decrements.
REQ-019 ROUND, r=0: state <= InvSubBytes(InvShiftRows(state)) ^ rnd_key_i with rnd_idx_o=0; InvMixColumns is skipped; go to DONE.
REQ-020 Latency: acceptance in cycle N SHALL give out_valid_o=1 in cycle N+11.
REQ-021 DONE: out_valid_o=1 and plain_o=state, held stable until out_ready_i=1; then go to IDLE with out_valid_o=0 the next cycle.
REQ-022 in_ready_o SHALL be 0 in ROUND and DONE; in_valid_i is ignored there.
REQ-023 Back-to-back: minimum spacing between acceptances SHALL be 12 cycles. A new request cannot be accepted in the DONE-exit cycle.
REQ-024 abort_i=1 in any state SHALL, at the next edge, go to IDLE with out_valid_o=0; state contents are don't-care. abort_i takes priority over in_valid_i and out_ready_i in the same cycle.
REQ-025 plain_o SHALL be the registered state: a glitch-free register output, unchanged while out_valid_o=1.
REQ-026 rnd_idx_o SHALL be a pure function of FSM state and counter, so the key store may decode it combinationally. In DONE it SHALL be 0.

Reset
REQ-027 nrst=0 at a clock edge SHALL set the FSM to IDLE, the counter to 9, the state register to 0, out_valid_o=0 and busy_o=0.
REQ-028 In the cycle after reset, in_ready_o=1 and rnd_idx_o=10.
REQ-029 Reset asserted mid-ROUND or in DONE SHALL discard the operation; no plaintext is emitted.

Structure
REQ-030 aes_pkg SHALL hold the aes_128 typedef, the inv_sbox table/function, an inv_shift_rows function and the constant NR=10.
REQ-031 InvMixColumns SHALL be the sub-module aes_inv_mix_column (state_i/state_o, combinational).
REQ-032 The datapath SHALL be a single 128-bit state register plus a 4-bit counter; there is no extra pipeline stage.

Verification
REQ-033 FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, cipher_i=69c4e0d86a7b0430d8cdb78070b4c55a -> plain_o=00112233445566778899aabbccddeeff, out_valid_o in cycle N+11.
REQ-034 FIPS-197 B vector: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_i=3925841d02dc09fbdc118597196a0b32 -> plain_o=3243f6a8885a308d313198a2e0370734. The bench checks the rnd_idx_o sequence 10,9,...,0.
REQ-035 Backpressure: out_ready_i=0 for 20 cycles -> out_valid_o and plain_o stay stable, in_ready_o=0 throughout, and output is released on the first out_ready_i=1.
REQ-036 abort_i pulse at round r=5 -> IDLE next cycle, out_valid_o never rises; a following C.1 request decrypts correctly.
REQ-037 nrst=0 during DONE with out_ready_i=0 -> out_valid_o=0, in_ready_o=1 and rnd_idx_o=10 after release.
REQ-038 in_valid_i held high continuously with two vectors -> exactly two acceptances 12 cycles apart, both plaintexts correct and in order.
